// File: rtl/ransac_fixed.sv
// Shared signed Q16.16 fixed-point format, Newton mode and FMA opcode types,
// plus the constants the refinement loop is built from.
package ransac_fixed;

    localparam int unsigned VALUE_W = 32;
    localparam int unsigned FRAC_W  = 16;

    typedef logic signed [VALUE_W-1:0] fixed_t;

    typedef enum logic {
        RSQRT = 1'b0,
        RECIP = 1'b1
    } newton_mode_t;

    typedef enum logic [1:0] {
        FMA_OPCODE_POS_A_POS_C = 2'd0,
        FMA_OPCODE_NEG_A_POS_C = 2'd1,
        FMA_OPCODE_POS_A_NEG_C = 2'd2,
        FMA_OPCODE_NEG_A_NEG_C = 2'd3
    } fma_opcode_t;

    function automatic int unsigned value_bits();
        return VALUE_W;
    endfunction

    function automatic int unsigned frac_bits();
        return FRAC_W;
    endfunction

    function automatic fixed_t one();
        return fixed_t'(1) << FRAC_W;
    endfunction

    function automatic fixed_t two();
        return one() << 1;
    endfunction

    function automatic fixed_t three();
        return one() + (one() << 1);
    endfunction

endpackage

// File: rtl/slow_fp_fused_multiply_add.sv
// Pipelined fixed-point fused multiply-add, r = (+/-a)*b + (+/-c), with a fixed
// issue-to-output latency; the product is truncated toward -inf and wraps.
module slow_fp_fused_multiply_add
    import ransac_fixed::*;
#(
    parameter int unsigned latency        = 1,
    parameter bit          reset_polarity = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    output logic        input_ready,
    input  fma_opcode_t opcode,
    input  fixed_t      a,
    input  fixed_t      b,
    input  fixed_t      c,
    output logic        output_valid,
    output fixed_t      result
);

    localparam int unsigned PROD_W = 2 * VALUE_W;

    logic                     reset_active;
    fixed_t                   a_eff;
    fixed_t                   c_eff;
    fixed_t                   sum;
    logic signed [PROD_W-1:0] product;
    logic [latency-1:0]       valid_pipe;
    fixed_t                   result_pipe [latency];

    assign reset_active = (reset == reset_polarity);
    assign input_ready  = 1'b1;

    // Operand sign selection and the single-cycle arithmetic feeding the pipe.
    always_comb begin
        a_eff = a;
        c_eff = c;
        case (opcode)
            FMA_OPCODE_NEG_A_POS_C: a_eff = -a;
            FMA_OPCODE_POS_A_NEG_C: c_eff = -c;
            FMA_OPCODE_NEG_A_NEG_C: begin
                a_eff = -a;
                c_eff = -c;
            end
            default: ;
        endcase
        product = PROD_W'(a_eff) * PROD_W'(b);
        sum     = fixed_t'(product >>> FRAC_W) + c_eff;
    end

    always_ff @(posedge clock) begin
        if (reset_active) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= input_valid;
            for (int i = 1; i < int'(latency); i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        result_pipe[0] <= sum;
        for (int i = 1; i < int'(latency); i++) begin
            result_pipe[i] <= result_pipe[i-1];
        end
    end

    assign output_valid = valid_pipe[latency-1];
    assign result       = result_pipe[latency-1];

endmodule

// File: rtl/newtons_method_iterative.sv
// Multi-iteration Newton-Raphson refinement (1/sqrt(x) or 1/x) sequenced over a
// single shared FMA, with valid/ready on both sides and domain-error reporting.
module newtons_method_iterative
    import ransac_fixed::*;
#(
    parameter int unsigned multiply_latency = ransac_fixed::value_bits() / 16,
    parameter int unsigned max_iterations   = 4,
    parameter int unsigned iter_w           = $clog2(max_iterations + 1),
    parameter bit          reset_polarity   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              input_valid,
    output logic              input_ready,
    input  logic              mode,
    input  logic [iter_w-1:0] iterations,
    input  fixed_t            number,
    input  fixed_t            initial_guess,
    output logic              output_valid,
    input  logic              output_ready,
    output fixed_t            result,
    output logic [iter_w-1:0] iterations_done,
    output logic              domain_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [iter_w-1:0] MAX_ITER = iter_w'(max_iterations);

    logic [1:0]        state_q, state_n;
    newton_mode_t      mode_q, mode_n;
    fixed_t            x_q, x_n;
    fixed_t            g_q, g_n;
    fixed_t            prev_q, prev_n;
    logic [1:0]        op_q, op_n;
    logic [iter_w-1:0] iter_q, iter_n;
    logic [iter_w-1:0] req_q, req_n;
    fixed_t            result_n;
    logic [iter_w-1:0] iterations_done_n;
    logic              domain_error_n;

    logic [iter_w-1:0] req_clamped;
    logic              req_domain_error;
    logic              last_op;
    fixed_t            g_next;

    logic   fma_reset;
    logic   fma_input_valid;
    logic   fma_input_ready;
    fixed_t fma_a;
    fixed_t fma_c;
    logic   fma_output_valid;
    fixed_t fma_result;

    // The FMA shares our active-high reset whatever polarity it is built for.
    assign fma_reset = reset_polarity ? reset : ~reset;

    slow_fp_fused_multiply_add #(
        .latency        (multiply_latency),
        .reset_polarity (reset_polarity)
    ) u_fma (
        .clock        (clock),
        .reset        (fma_reset),
        .input_valid  (fma_input_valid),
        .input_ready  (fma_input_ready),
        .opcode       (FMA_OPCODE_POS_A_POS_C),
        .a            (fma_a),
        .b            (g_q),
        .c            (fma_c),
        .output_valid (fma_output_valid),
        .result       (fma_result)
    );

    assign req_clamped      = (iterations > MAX_ITER) ? MAX_ITER : iterations;
    assign req_domain_error = mode ? (number == fixed_t'(0)) : (number <= fixed_t'(0));

    // Operand schedule: every op multiplies by g; a and c depend on mode and op.
    always_comb begin
        fma_a   = prev_q;
        fma_c   = '0;
        last_op = 1'b0;
        if (mode_q == RSQRT) begin
            last_op = (op_q == 2'd2);
            case (op_q)
                2'd0: fma_a = x_q;
                2'd1: begin
                    fma_a = -prev_q;
                    fma_c = three();
                end
                default: fma_a = prev_q;
            endcase
        end else begin
            last_op = (op_q == 2'd1);
            if (op_q == 2'd0) begin
                fma_a = -x_q;
                fma_c = two();
            end
        end
    end

    always_comb begin
        state_n           = state_q;
        mode_n            = mode_q;
        x_n               = x_q;
        g_n               = g_q;
        prev_n            = prev_q;
        op_n              = op_q;
        iter_n            = iter_q;
        req_n             = req_q;
        result_n          = result;
        iterations_done_n = iterations_done;
        domain_error_n    = domain_error;
        fma_input_valid   = 1'b0;
        g_next            = (mode_q == RSQRT) ? (fma_result >>> 1) : fma_result;

        case (state_q)
            S_IDLE: begin
                if (input_valid && input_ready) begin
                    mode_n = newton_mode_t'(mode);
                    x_n    = number;
                    g_n    = initial_guess;
                    req_n  = req_clamped;
                    op_n   = '0;
                    iter_n = '0;
                    if (req_domain_error) begin
                        state_n           = S_DONE;
                        result_n          = '0;
                        domain_error_n    = 1'b1;
                        iterations_done_n = '0;
                    end else if (req_clamped == '0) begin
                        state_n           = S_DONE;
                        result_n          = initial_guess;
                        domain_error_n    = 1'b0;
                        iterations_done_n = '0;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (fma_input_ready) begin
                    fma_input_valid = 1'b1;
                    state_n         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fma_output_valid) begin
                    prev_n = fma_result;
                    if (!last_op) begin
                        op_n    = op_q + 2'd1;
                        state_n = S_ISSUE;
                    end else begin
                        g_n    = g_next;
                        op_n   = '0;
                        iter_n = iter_q + iter_w'(1);
                        if (iter_n < req_q) begin
                            state_n = S_ISSUE;
                        end else begin
                            state_n           = S_DONE;
                            result_n          = g_next;
                            domain_error_n    = 1'b0;
                            iterations_done_n = iter_n;
                        end
                    end
                end
            end
            default: begin
                if (output_ready) begin
                    state_n = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            mode_q          <= RSQRT;
            x_q             <= '0;
            g_q             <= '0;
            prev_q          <= '0;
            op_q            <= '0;
            iter_q          <= '0;
            req_q           <= '0;
            input_ready     <= 1'b1;
            output_valid    <= 1'b0;
            result          <= '0;
            iterations_done <= '0;
            domain_error    <= 1'b0;
        end else begin
            state_q         <= state_n;
            mode_q          <= mode_n;
            x_q             <= x_n;
            g_q             <= g_n;
            prev_q          <= prev_n;
            op_q            <= op_n;
            iter_q          <= iter_n;
            req_q           <= req_n;
            input_ready     <= (state_n == S_IDLE);
            output_valid    <= (state_n == S_DONE);
            result          <= result_n;
            iterations_done <= iterations_done_n;
            domain_error    <= domain_error_n;
        end
    end

endmodule

// File: doc/newtons_method_iterative.md
# newtons_method_iterative

Multi-iteration Newton–Raphson refinement engine for `ransac_fixed::fixed_t`.
- Modes: reciprocal square root (`1/sqrt(x)`) and reciprocal (`1/x`).
- Runs a per-request number of iterations internally on a single shared fused multiply-add.
- Downstream consumers (vector normalisation, plane-fit division) get a refined result from one handshake instead of re-feeding a single-step block.
- Full valid/ready on both sides, plus domain-error detection for invalid inputs.

## Interface

Parameters:
- `multiply_latency`, default `ransac_fixed::value_bits() / 16`: latency passed to the FMA instance.
- `max_iterations`, default 4: upper bound on iterations per request. Must be ≥ 1.
- `iter_w`, default `$clog2(max_iterations + 1)`: width of the iteration-count fields.
- `reset_polarity`, default 1: kept for FMA instance compatibility. This block's own reset is fixed active-high.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `input_valid`  in  1  request present.
- `input_ready`  out  1  block can accept a request.
- `mode`  in  1  0 = rsqrt, 1 = reciprocal.
- `iterations`  in  `iter_w`  number of iterations requested. Values above `max_iterations` are clamped to `max_iterations`.
- `number`  in  fixed_t  operand x.
- `initial_guess`  in  fixed_t  starting guess g0.
- `output_valid`  out  1  result present.
- `output_ready`  in  1  consumer accepts the result.
- `result`  out  fixed_t  refined guess.
- `iterations_done`  out  `iter_w`  iterations actually executed.
- `domain_error`  out  1  operand outside the valid domain; `result` is forced to 0.

## Operation

Handshakes:
- A request is accepted on a cycle where `input_valid && input_ready`. On acceptance the block latches `number`, `initial_guess`, `mode` and the clamped `iterations`.
- `input_ready` is 1 only in IDLE.
- A result transfers on a cycle where `output_valid && output_ready`.

Iteration arithmetic (each step is one FMA op, `r = a*b + c`; the block negates operands itself with two's complement):
- rsqrt, g' = g·(3 − x·g²)/2:
  - op0: `a=x, b=g, c=0` → t.
  - op1: `a=−t, b=g, c=3.0` → u.
  - op2: `a=u, b=g, c=0` → v.
  - g' = `v >>> 1` (arithmetic shift).
- reciprocal, g' = g·(2 − x·g):
  - op0: `a=−x, b=g, c=2.0` → t.
  - op1: `a=t, b=g, c=0` → g'.
- Constants are built from `ransac_fixed::one()`: 2.0 = `one()<<1`, 3.0 = `one()+(one()<<1)`.
- Overflow wraps, as the FMA does. No saturation.

Domain check (at acceptance):
- Error condition: rsqrt with `number ≤ 0`, or reciprocal with `number == 0`.
- Response: go directly to DONE with `result=0`, `domain_error=1`, `iterations_done=0`. The FMA is not issued.

Zero iterations:
- `iterations == 0` (after the domain check passes) goes to DONE with `result=initial_guess`, `iterations_done=0`.

State machine:
- IDLE: on accept → DONE if domain error or zero iterations; otherwise → ISSUE with op=0, iter=0, g=g0.
- ISSUE: drive FMA operands for the current op and pulse `fma_input_valid` for exactly 1 cycle when `fma_input_ready` is high; → WAIT.
- WAIT: on `fma_output_valid`, capture r.
  - If not the last op: op++ → ISSUE.
  - If the last op: update g, iter++, op=0. Then → ISSUE if iter < requested, else → DONE.
- DONE: `output_valid=1`, outputs held stable until `output_ready`, then → IDLE.

Reset values: state IDLE, `input_ready=1`, `output_valid=0`, `result=0`, `iterations_done=0`, `domain_error=0`, `fma_input_valid=0`.

Reset mid-operation: the block returns to IDLE on the next edge and the in-flight result is discarded. The FMA is reset on the same signal, so no stale `fma_output_valid` may be consumed.

## Timing

- Let L be the FMA issue-to-output latency. Each op costs 1 (ISSUE) + L (WAIT) cycles.
- Accept-to-`output_valid` latency:
  - `1 + N·3·(L+1)` for rsqrt.
  - `1 + N·2·(L+1)` for reciprocal.
  - 1 cycle for domain error or N=0.
- At most one FMA op is outstanding at any time.
- No new request is accepted while a result is pending. The next accept can occur at the earliest 1 cycle after the output transfer.
- `output_ready` held low stalls the block indefinitely in DONE with outputs constant.

## Structure

- In `ransac_fixed`: a `newton_mode_t` enum (RSQRT, RECIP), and `two()`/`three()` constant functions.
- Sub-module: one `slow_fp_fused_multiply_add` instance (opcode `FMA_OPCODE_POS_A_POS_C`). No other sub-modules.

## Test plan

- rsqrt, x=4.0, g0=0.5, N=1 → result 0.5 exactly, `iterations_done=1`, latency `1+3(L+1)`.
- rsqrt, x=4.0, g0=0.4, N=1 → 0.472 (±1 LSB); with N=3 → 0.5 (±2 LSB), `iterations_done=3`.
- reciprocal, x=4.0, g0=0.2, N=2 → 0.2496 (±1 LSB); `iterations=7` with `max_iterations=4` → `iterations_done=4`.
- rsqrt with x=0, rsqrt with x=−1.0, reciprocal with x=0 → `domain_error=1`, `result=0`, 1-cycle latency, no FMA `input_valid` pulse; N=0 → `result=g0`.
- `output_ready` low for 20 cycles in DONE → outputs stable, `input_ready=0`, second request not accepted until after the transfer.
- Reset asserted during WAIT of iteration 2 → next cycle IDLE, `output_valid=0`; a fresh request then completes correctly.
